muxkey_table: RTL and testbench

MUXKEY_TABLE -- requirements
Module: muxkey_table

---
 rtl/muxkey_table.sv | 130 +++++++++++++
 tb/tb_muxkey_table.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/muxkey_table.sv
// rtl/muxkey_table.sv - keyed lookup table with one-cycle registered response and ready/valid handshake
// Optional hit/miss statistics counters enabled by defining MUXKEY_TABLE_STATS_EN.
module muxkey_table #(
    parameter int NR_KEY   = 8,
    parameter int KEY_LEN  = 8,
    parameter int DATA_LEN = 32,
    parameter int IDX_LEN  = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                wr_vld,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    input  logic [DATA_LEN-1:0] default_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic [IDX_LEN-1:0]  rsp_idx
`ifdef MUXKEY_TABLE_STATS_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    logic [NR_KEY-1:0]   r_vld;
    logic [KEY_LEN-1:0]  r_key  [NR_KEY];
    logic [DATA_LEN-1:0] r_data [NR_KEY];

    logic                r_rsp_valid;
    logic [DATA_LEN-1:0] r_rsp_data;
    logic                r_rsp_hit;
    logic [IDX_LEN-1:0]  r_rsp_idx;

    logic                w_wr_ok;
    logic                w_accept;
    logic                w_hit;
    logic [IDX_LEN-1:0]  w_idx;
    logic [DATA_LEN-1:0] w_data;

    assign w_wr_ok   = wr_en && ({1'b0, wr_idx} < (IDX_LEN+1)'(NR_KEY));
    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    // Valid bits: write is applied after clr so a same-cycle write survives the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (clr) begin
                r_vld <= '0;
            end
            if (w_wr_ok) begin
                r_vld[wr_idx] <= wr_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_key[wr_idx]  <= wr_key;
            r_data[wr_idx] <= wr_data;
        end
    end

    // Scan from the top so the lowest matching index wins.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_data = default_out;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_key[i] == req_key)) begin
                w_hit  = 1'b1;
                w_idx  = IDX_LEN'(i);
                w_data = r_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_idx   <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_data;
            r_rsp_hit   <= w_hit;
            r_rsp_idx   <= w_idx;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_idx   = r_rsp_idx;

`ifdef MUXKEY_TABLE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (!w_hit && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_muxkey_table.sv
// tb/tb_muxkey_table.sv - cycle table of stimulus with expected responses, checked through a response queue
module tb_muxkey_table;

    logic        clk = 1'b0;
    logic        rst, wr_en, wr_vld, clr, req_valid, rsp_ready;
    logic [2:0]  wr_idx;
    logic [7:0]  wr_key, req_key;
    logic [31:0] wr_data, default_out;
    logic        req_ready, rsp_valid, rsp_hit;
    logic [31:0] rsp_data;
    logic [2:0]  rsp_idx;
`ifdef MUXKEY_TABLE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    muxkey_table dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
        .wr_data(wr_data), .wr_vld(wr_vld), .clr(clr), .req_valid(req_valid),
        .req_ready(req_ready), .req_key(req_key), .default_out(default_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
`ifdef MUXKEY_TABLE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    typedef struct {
        logic        rst, clr, wr_en;
        logic [2:0]  wr_idx;
        logic [7:0]  wr_key;
        logic [31:0] wr_data;
        logic        wr_vld, req_valid;
        logic [7:0]  req_key;
        logic [31:0] dflt;
        logic        rsp_ready, exp_hit;
        logic [31:0] exp_data;
        logic [2:0]  exp_idx;
    } vec_t;

    typedef struct packed {
        logic        hit;
        logic [31:0] data;
        logic [2:0]  idx;
    } rsp_t;

    localparam int NV = 27;
    vec_t  vecs [NV];
    rsp_t  q [$];
    rsp_t  head;
    int    n_vec = 0;
    int    n_err = 0;
    logic  exp_valid;
    logic  exp_ready;
    logic  acc;

    function automatic vec_t v(input logic r, c, we, input logic [2:0] wi, input logic [7:0] wk,
                               input logic [31:0] wd, input logic wv, rv, input logic [7:0] rk,
                               input logic [31:0] df, input logic rr, eh, input logic [31:0] ed,
                               input logic [2:0] ei);
        vec_t t;
        t.rst = r; t.clr = c; t.wr_en = we; t.wr_idx = wi; t.wr_key = wk; t.wr_data = wd;
        t.wr_vld = wv; t.req_valid = rv; t.req_key = rk; t.dflt = df; t.rsp_ready = rr;
        t.exp_hit = eh; t.exp_data = ed; t.exp_idx = ei;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        rst = t.rst; clr = t.clr; wr_en = t.wr_en; wr_idx = t.wr_idx; wr_key = t.wr_key;
        wr_data = t.wr_data; wr_vld = t.wr_vld; req_valid = t.req_valid; req_key = t.req_key;
        default_out = t.dflt; rsp_ready = t.rsp_ready;
    endtask

    initial begin
        //             rst clr we  wi  wkey   wdata       wv rv rkey   dflt        rr eh edata       ei
        vecs[0]  = v(1, 0, 1, 0, 8'h12, 32'h0000_0011, 1, 1, 8'h12, 32'h0,     1, 0, 32'h0,     0);
        vecs[1]  = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h12, 32'hDEAD,  1, 0, 32'hDEAD,  0);
        vecs[2]  = v(0, 0, 1, 3, 8'h12, 32'hCAFE,      1, 0, 8'h00, 32'h0,     1, 0, 32'h0,     0);
        vecs[3]  = v(0, 0, 1, 5, 8'h12, 32'hBEEF,      1, 0, 8'h00, 32'h0,     1, 0, 32'h0,     0);
        vecs[4]  = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h12, 32'h0,     1, 1, 32'hCAFE,  3);
        vecs[5]  = v(0, 0, 1, 2, 8'h40, 32'h1,         1, 1, 8'h40, 32'h77,    1, 0, 32'h77,    0);
        vecs[6]  = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h40, 32'h0,     1, 1, 32'h1,     2);
        vecs[7]  = v(0, 0, 1, 3, 8'h12, 32'hCAFE,      0, 1, 8'h12, 32'h0,     1, 1, 32'hCAFE,  3);
        vecs[8]  = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h12, 32'h0,     1, 1, 32'hBEEF,  5);
        vecs[9]  = v(0, 0, 1, 0, 8'h55, 32'h123,       0, 0, 8'h00, 32'h0,     1, 0, 32'h0,     0);
        vecs[10] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h55, 32'hAA,    1, 0, 32'hAA,    0);
        vecs[11] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h40, 32'h0,     0, 1, 32'h1,     2);
        vecs[12] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h40, 32'h0,     0, 1, 32'h1,     2);
        vecs[13] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h40, 32'h0,     0, 1, 32'h1,     2);
        vecs[14] = v(0, 0, 1, 5, 8'h55, 32'h5,         1, 1, 8'h40, 32'h0,     0, 1, 32'h1,     2);
        vecs[15] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h40, 32'h0,     1, 1, 32'h1,     2);
        vecs[16] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h55, 32'h0,     1, 1, 32'h5,     5);
        vecs[17] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h12, 32'h33,    1, 0, 32'h33,    0);
        vecs[18] = v(0, 1, 1, 1, 8'h07, 32'h9,         1, 0, 8'h00, 32'h0,     1, 0, 32'h0,     0);
        vecs[19] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h12, 32'hBB,    1, 0, 32'hBB,    0);
        vecs[20] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h07, 32'h0,     1, 1, 32'h9,     1);
        vecs[21] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 0, 8'h00, 32'h0,     1, 0, 32'h0,     0);
        vecs[22] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h07, 32'h0,     0, 1, 32'h9,     1);
        vecs[23] = v(1, 0, 0, 0, 8'h00, 32'h0,         0, 0, 8'h00, 32'h0,     0, 0, 32'h0,     0);
        vecs[24] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h07, 32'hC,     1, 0, 32'hC,     0);
        vecs[25] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 1, 8'h40, 32'hD,     1, 0, 32'hD,     0);
        vecs[26] = v(0, 0, 0, 0, 8'h00, 32'h0,         0, 0, 8'h00, 32'h0,     1, 0, 32'h0,     0);

        apply(vecs[26]);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_hit",   32'(rsp_hit),   32'd0);
        chk("reset rsp_data",  rsp_data,       32'd0);
        chk("reset rsp_idx",   32'(rsp_idx),   32'd0);
        exp_valid = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
            @(negedge clk);
            exp_ready = !exp_valid || vecs[i].rsp_ready;
            chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(exp_ready));
            chk($sformatf("row%0d rsp_valid", i), 32'(rsp_valid), 32'(exp_valid));
            if (exp_valid) begin
                if (q.size() == 0) begin
                    chk($sformatf("row%0d queue empty", i), 32'd0, 32'd1);
                end else begin
                    head = q[0];
                    chk($sformatf("row%0d rsp_hit", i),  32'(rsp_hit), 32'(head.hit));
                    chk($sformatf("row%0d rsp_data", i), rsp_data,     head.data);
                    chk($sformatf("row%0d rsp_idx", i),  32'(rsp_idx), 32'(head.idx));
                end
            end
`ifdef MUXKEY_TABLE_STATS_EN
            if (i == 21) begin
                chk("hit_cnt after clr", hit_cnt, 32'd1);
                chk("miss_cnt after clr", miss_cnt, 32'd1);
            end
`endif
            if (vecs[i].rst) begin
                q.delete();
                exp_valid = 1'b0;
            end else begin
                if (exp_valid && vecs[i].rsp_ready) void'(q.pop_front());
                acc = vecs[i].req_valid && exp_ready;
                if (acc) q.push_back({vecs[i].exp_hit, vecs[i].exp_data, vecs[i].exp_idx});
                exp_valid = acc ? 1'b1 : (vecs[i].rsp_ready ? 1'b0 : exp_valid);
            end
        end

        // Drain: response channel must go idle within a bounded number of cycles.
        begin
            int n = 0;
            while (rsp_valid === 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("drain rsp_valid", 32'(rsp_valid), 32'd0);
            chk("drain queue", 32'(q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
